// File: rtl/uart_tx_fifo_drain.sv
// FIFO read-side drain: pops one word per frame and shifts it out as UART 8N1 (LSB first).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bits.
module uart_tx_fifo_drain #(
    parameter int DATA_SIZE    = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_rd_data,
    output logic                 fifo_rd,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done_tick
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_SIZE + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_SIZE - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_n;
    logic [BW-1:0]        baud, baud_n;
    logic [IW-1:0]        bit_idx, idx_n;
    logic [DATA_SIZE-1:0] shift_reg, shift_n;
    logic                 tx_q, tx_n;
    logic                 baud_last;

`ifdef UART_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (reset)        parity_q <= 1'b0;
        else if (fifo_rd) parity_q <= ^fifo_rd_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_q      <= 1'b1;
        end else begin
            state     <= state_n;
            baud      <= baud_n;
            bit_idx   <= idx_n;
            shift_reg <= shift_n;
            tx_q      <= tx_n;
        end
    end

    assign baud_last = (baud == BAUD_LAST);

    // tx_n is the line level for the next cycle, so tx stays a pure flop output.
    always_comb begin
        state_n      = state;
        baud_n       = baud;
        idx_n        = bit_idx;
        shift_n      = shift_reg;
        tx_n         = tx_q;
        fifo_rd      = 1'b0;
        tx_done_tick = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                // Gated by reset so a held reset never pops a word it would then discard.
                if (!reset && enable && !fifo_empty) begin
                    fifo_rd = 1'b1;
                    shift_n = fifo_rd_data;
                    baud_n  = '0;
                    idx_n   = '0;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    idx_n   = '0;
                    tx_n    = shift_reg[0];
                    state_n = DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_n  = '0;
                    shift_n = shift_reg >> 1;
                    if (bit_idx == DATA_LAST) begin
                        idx_n   = '0;
`ifdef UART_TX_PARITY_EN
                        tx_n    = parity_q;
                        state_n = PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = bit_idx + 1'b1;
                        tx_n  = shift_n[0];
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_n  = '0;
                    idx_n   = '0;
                    tx_n    = 1'b1;
                    state_n = STOP;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
`endif
            STOP: begin
                // bit_idx counts stop bits here so the baud counter stays one bit-time wide.
                if (baud_last) begin
                    baud_n = '0;
                    if (bit_idx == STOP_LAST) begin
                        tx_done_tick = 1'b1;
                        idx_n        = '0;
                        tx_n         = 1'b1;
                        state_n      = IDLE;
                    end else begin
                        idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = (state != IDLE) || fifo_rd;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: small FIFO model, per-frame bit capture and timing checks.
// Build with UART_TX_PARITY_EN defined to also exercise the parity frames.
module tb_uart_tx_fifo_drain;

    localparam int CPB = 4;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd, tx, tx_busy, tx_done_tick;

    logic [7:0] fifo_mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         pops = 0;
    int         bad_rd = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    uart_tx_fifo_drain #(.DATA_SIZE(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd(fifo_rd), .tx(tx),
        .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
    );

    always #5 clk = ~clk;

    assign fifo_empty   = (rd_ptr == wr_ptr);
    assign fifo_rd_data = fifo_mem[rd_ptr[3:0]];

    always @(posedge clk) begin
        if (fifo_rd && !fifo_empty) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    always @(negedge clk) if (fifo_rd && fifo_empty) bad_rd++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        fifo_mem[wr_ptr[3:0]] = d;
        wr_ptr++;
    endtask

    // Waits for the pop, then samples every cycle of the frame; drop_cyc>0 clears enable on that cycle.
    task automatic run_frame(input logic [7:0] d, input int drop_cyc, output int gap);
        logic [31:0] exp_bits, obs_bits;
        int unstable, busy_low, done_n, done_pos, b;
        exp_bits = '0;
        obs_bits = '0;
        exp_bits[8:1] = d;
`ifdef UART_TX_PARITY_EN
        exp_bits[9]  = ^d;
        exp_bits[10] = 1'b1;
`else
        exp_bits[9]  = 1'b1;
`endif
        unstable = 0; busy_low = 0; done_n = 0; done_pos = 0;
        gap = 0;
        while (!fifo_rd && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        chk("pop_seen", {31'd0, fifo_rd}, 32'd1);
        if (!fifo_rd) return;
        chk("pop_busy", {31'd0, tx_busy}, 32'd1);
        for (int k = 1; k <= NB * CPB; k++) begin
            @(negedge clk);
            b = (k - 1) / CPB;
            if ((k - 1) % CPB == 0) obs_bits[b] = tx;
            else if (tx !== obs_bits[b]) unstable++;
            if (!tx_busy) busy_low++;
            if (tx_done_tick) begin
                done_n++;
                done_pos = k;
            end
            if (k == drop_cyc) enable = 1'b0;
        end
        chk("frame_bits", obs_bits, exp_bits);
        chk("bit_stable", unstable, 0);
        chk("busy_low", busy_low, 0);
        chk("done_count", done_n, 1);
        chk("done_pos", done_pos, NB * CPB);
    endtask

    initial begin
        int g, p0, rd_hi, tx_hi, busy_hi, ticks;

        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_rd", {31'd0, fifo_rd}, 32'd0);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_done", {31'd0, tx_done_tick}, 32'd0);
        reset = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // single frame 0xA5
        p0 = pops;
        push(8'hA5);
        #1;
        run_frame(8'hA5, 0, g);
        chk("a5_gap", g, 0);
        repeat (5) @(negedge clk);
        chk("a5_pops", pops - p0, 1);

        // back-to-back frames
        p0 = pops;
        push(8'h3C); push(8'hFF); push(8'h00);
        #1;
        run_frame(8'h3C, 0, g);
        chk("b2b_gap0", g, 0);
        run_frame(8'hFF, 0, g);
        chk("b2b_gap1", g, 1);
        run_frame(8'h00, 0, g);
        chk("b2b_gap2", g, 1);
        rd_hi = 0; tx_hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_rd) rd_hi++;
            if (tx) tx_hi++;
        end
        chk("b2b_pops", pops - p0, 3);
        chk("b2b_empty", {31'd0, fifo_empty}, 32'd1);
        chk("b2b_idle_rd", rd_hi, 0);
        chk("b2b_idle_tx", tx_hi, 20);

        // empty FIFO with enable high
        rd_hi = 0; tx_hi = 0; busy_hi = 0;
        repeat (100) begin
            @(negedge clk);
            if (fifo_rd) rd_hi++;
            if (tx) tx_hi++;
            if (tx_busy) busy_hi++;
        end
        chk("empty_rd", rd_hi, 0);
        chk("empty_tx", tx_hi, 100);
        chk("empty_busy", busy_hi, 0);

        // enable dropped at data bit 3 of 0x81 with 0x42 queued
        p0 = pops;
        push(8'h81); push(8'h42);
        #1;
        run_frame(8'h81, 17, g);
        chk("en_gap", g, 0);
        repeat (30) @(negedge clk);
        chk("en_held_pops", pops - p0, 1);
        chk("en_held_nonempty", {31'd0, fifo_empty}, 32'd0);
        enable = 1'b1;
        #1;
        run_frame(8'h42, 0, g);
        chk("en_resume_gap", g, 0);
        chk("en_pops", pops - p0, 2);

        // reset during data bit 5 of 0x5A, 0xC3 queued behind it
        repeat (3) @(negedge clk);
        p0 = pops;
        push(8'h5A); push(8'hC3);
        #1;
        chk("rst5a_pop", {31'd0, fifo_rd}, 32'd1);
        ticks = 0;
        repeat (25) begin
            @(negedge clk);
            if (tx_done_tick) ticks++;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
        chk("midrst_rd", {31'd0, fifo_rd}, 32'd0);
        chk("midrst_ticks", ticks, 0);
        reset = 1'b0;
        #1;
        run_frame(8'hC3, 0, g);
        chk("postrst_gap", g, 0);
        chk("postrst_pops", pops - p0, 2);

`ifdef UART_TX_PARITY_EN
        repeat (3) @(negedge clk);
        push(8'h07); push(8'h03);
        #1;
        run_frame(8'h07, 0, g);
        run_frame(8'h03, 0, g);
        chk("par_gap", g, 1);
`endif

        repeat (5) @(negedge clk);
        chk("rd_when_empty", bad_rd, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
